// File: rtl/copperv_enums_pkg.sv
// copperv_enums_pkg: shared enumerations and helpers for the copperv core.
// Holds the write-response encoding and bus response width, the memory access
// size encoding, the load/store unit state encoding and the per-size byte mask.
package copperv_enums_pkg;

  localparam int bus_resp_width = 1;

  typedef enum logic [bus_resp_width-1:0] {
    data_write_resp_error = 1'b0,
    data_write_resp_ok    = 1'b1
  } data_write_resp_e;

  typedef enum logic [1:0] {
    mem_size_byte,
    mem_size_hword,
    mem_size_word,
    mem_size_dword
  } mem_size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR,
    S_WR_RESP,
    S_DONE
  } lsu_state_e;

  // Byte-enable pattern of an access before it is moved to its lane offset.
  function automatic logic [7:0] size_mask(input mem_size_e size);
    case (size)
      mem_size_byte:  size_mask = 8'h01;
      mem_size_hword: size_mask = 8'h03;
      mem_size_word:  size_mask = 8'h0F;
      default:        size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/copperv_lsu_align.sv
// copperv_lsu_align: combinational lane alignment for the load/store unit.
// Ports:
//   size, offset, is_unsigned : access size, byte offset within the bus word,
//                               zero-extend flag for loads
//   store_data / store_shifted: right-aligned store data in, lane-placed out
//   load_data / load_ext      : raw bus read data in, extracted and extended out
//   strobe                    : byte enables for a store
//   misaligned                : access does not fit naturally at this offset
module copperv_lsu_align
  import copperv_enums_pkg::*;
#(
  parameter int data_width = 32,
  localparam int lanes = data_width / 8,
  localparam int off_w = $clog2(lanes)
) (
  input  mem_size_e              size,
  input  logic [off_w-1:0]       offset,
  input  logic                   is_unsigned,
  input  logic [data_width-1:0]  store_data,
  input  logic [data_width-1:0]  load_data,
  output logic [lanes-1:0]       strobe,
  output logic [data_width-1:0]  store_shifted,
  output logic [data_width-1:0]  load_ext,
  output logic                   misaligned
);

  logic [7:0]            mask8;
  logic [data_width-1:0] shifted;
  logic [data_width-1:0] keep;
  logic                  sign;

  always_comb begin
    mask8      = size_mask(size);
    shifted    = load_data >> {offset, 3'b000};
    misaligned = 1'b0;
    keep       = '1;
    sign       = 1'b0;
    case (size)
      mem_size_byte: begin
        keep = data_width'(64'hFF);
        sign = shifted[7];
      end
      mem_size_hword: begin
        misaligned = offset[0];
        keep       = data_width'(64'hFFFF);
        sign       = shifted[15];
      end
      mem_size_word: begin
        misaligned = (offset[1:0] != 2'b00);
        keep       = data_width'(64'hFFFF_FFFF);
        sign       = shifted[31];
      end
      default: begin
        // A dword cannot be carried by a 32-bit bus at all.
        misaligned = (data_width == 32) || (offset != '0);
        keep       = '1;
        sign       = shifted[data_width-1];
      end
    endcase
    sign          = sign & ~is_unsigned;
    load_ext      = (shifted & keep) | ({data_width{sign}} & ~keep);
    strobe        = mask8[lanes-1:0] << offset;
    store_shifted = store_data << {offset, 3'b000};
  end

endmodule

// File: rtl/copperv_lsu.sv
// copperv_lsu: load/store unit between the core and the split data bus.
// Takes one request at a time, checks alignment, runs the read (address then
// data) or write (request then response) handshakes and returns a one-cycle
// response pulse carrying the extended load data and an error flag.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   req_*                    : core request (valid/ready, write, size, unsigned,
//                              addr, wdata)
//   resp_valid/rdata/err     : one-cycle core response
//   dr_addr_*, dr_data_*     : read address and read data channels
//   dw_valid/ready/addr/data/strobe : write request channel
//   dw_resp_valid/ready, dw_resp    : write response channel
module copperv_lsu
  import copperv_enums_pkg::*;
#(
  parameter int data_width     = 32,
  parameter int addr_width     = 32,
  parameter int resp_width     = bus_resp_width,
  parameter int timeout_cycles = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  mem_size_e               req_size,
  input  logic                    req_unsigned,
  input  logic [addr_width-1:0]   req_addr,
  input  logic [data_width-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [data_width-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    dr_addr_valid,
  input  logic                    dr_addr_ready,
  output logic [addr_width-1:0]   dr_addr,
  input  logic                    dr_data_valid,
  output logic                    dr_data_ready,
  input  logic [data_width-1:0]   dr_data,
  output logic                    dw_valid,
  input  logic                    dw_ready,
  output logic [addr_width-1:0]   dw_addr,
  output logic [data_width-1:0]   dw_data,
  output logic [data_width/8-1:0] dw_strobe,
  input  logic                    dw_resp_valid,
  output logic                    dw_resp_ready,
  input  logic [resp_width-1:0]   dw_resp
);

  localparam int lanes = data_width / 8;
  localparam int off_w = $clog2(lanes);
  localparam int cnt_w = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

  lsu_state_e             state;
  mem_size_e              size_q;
  logic                   unsigned_q;
  logic [off_w-1:0]       offset_q;
  logic [cnt_w-1:0]       cnt;

  mem_size_e              sel_size;
  logic [off_w-1:0]       sel_offset;
  logic                   sel_unsigned;
  logic [lanes-1:0]       strobe;
  logic [data_width-1:0]  store_shifted;
  logic [data_width-1:0]  load_ext;
  logic                   misaligned;
  logic                   accept;
  logic                   expired;
  logic [addr_width-1:0]  aligned_addr;

  // In idle the aligner looks at the incoming request (alignment, strobes,
  // store shift); afterwards it works from the registered access for the load.
  always_comb begin
    sel_size     = size_q;
    sel_offset   = offset_q;
    sel_unsigned = unsigned_q;
    if (state == S_IDLE) begin
      sel_size     = req_size;
      sel_offset   = req_addr[off_w-1:0];
      sel_unsigned = req_unsigned;
    end
  end

  copperv_lsu_align #(.data_width(data_width)) u_align (
    .size          (sel_size),
    .offset        (sel_offset),
    .is_unsigned   (sel_unsigned),
    .store_data    (req_wdata),
    .load_data     (dr_data),
    .strobe        (strobe),
    .store_shifted (store_shifted),
    .load_ext      (load_ext),
    .misaligned    (misaligned)
  );

  assign accept       = req_valid & req_ready;
  assign aligned_addr = {req_addr[addr_width-1:off_w], {off_w{1'b0}}};
  assign expired      = (timeout_cycles != 0) && (cnt == cnt_w'(timeout_cycles - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      size_q        <= mem_size_byte;
      unsigned_q    <= 1'b0;
      offset_q      <= '0;
      cnt           <= '0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      resp_err      <= 1'b0;
      dr_addr_valid <= 1'b0;
      dr_addr       <= '0;
      dr_data_ready <= 1'b0;
      dw_valid      <= 1'b0;
      dw_addr       <= '0;
      dw_data       <= '0;
      dw_strobe     <= '0;
      dw_resp_ready <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept) begin
            req_ready  <= 1'b0;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            offset_q   <= req_addr[off_w-1:0];
            if (misaligned) begin
              state      <= S_DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write) begin
              state     <= S_WR;
              dw_valid  <= 1'b1;
              dw_addr   <= aligned_addr;
              dw_data   <= store_shifted;
              dw_strobe <= strobe;
            end else begin
              state         <= S_RD_ADDR;
              dr_addr_valid <= 1'b1;
              dr_addr       <= aligned_addr;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_RD_ADDR: begin
          if (dr_addr_ready) begin
            state         <= S_RD_DATA;
            dr_addr_valid <= 1'b0;
            dr_data_ready <= 1'b1;
            cnt           <= '0;
          end else if (expired) begin
            state         <= S_DONE;
            dr_addr_valid <= 1'b0;
            resp_valid    <= 1'b1;
            resp_err      <= 1'b1;
            resp_rdata    <= '0;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RD_DATA: begin
          if (dr_data_valid) begin
            state         <= S_DONE;
            dr_data_ready <= 1'b0;
            resp_valid    <= 1'b1;
            resp_err      <= 1'b0;
            resp_rdata    <= load_ext;
            cnt           <= '0;
          end else if (expired) begin
            state         <= S_DONE;
            dr_data_ready <= 1'b0;
            resp_valid    <= 1'b1;
            resp_err      <= 1'b1;
            resp_rdata    <= '0;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WR: begin
          if (dw_ready) begin
            state         <= S_WR_RESP;
            dw_valid      <= 1'b0;
            dw_resp_ready <= 1'b1;
            cnt           <= '0;
          end else if (expired) begin
            state      <= S_DONE;
            dw_valid   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WR_RESP: begin
          if (dw_resp_valid) begin
            state         <= S_DONE;
            dw_resp_ready <= 1'b0;
            resp_valid    <= 1'b1;
            resp_err      <= (dw_resp != resp_width'(data_write_resp_ok));
            resp_rdata    <= '0;
            cnt           <= '0;
          end else if (expired) begin
            state         <= S_DONE;
            dw_resp_ready <= 1'b0;
            resp_valid    <= 1'b1;
            resp_err      <= 1'b1;
            resp_rdata    <= '0;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          cnt        <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_copperv_lsu.sv
// tb_copperv_lsu: self-checking bench for copperv_lsu (32-bit bus, timeout 8).
// Each scenario pushes its expected response to a scoreboard queue when the
// request is driven and pops it when the response pulse appears.
module tb_copperv_lsu;
  import copperv_enums_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_write = 1'b0;
  mem_size_e       req_size = mem_size_byte;
  logic            req_unsigned = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [DW-1:0]   req_wdata = '0;
  logic            resp_valid;
  logic [DW-1:0]   resp_rdata;
  logic            resp_err;
  logic            dr_addr_valid;
  logic            dr_addr_ready = 1'b1;
  logic [AW-1:0]   dr_addr;
  logic            dr_data_valid = 1'b1;
  logic            dr_data_ready;
  logic [DW-1:0]   dr_data = '0;
  logic            dw_valid;
  logic            dw_ready = 1'b1;
  logic [AW-1:0]   dw_addr;
  logic [DW-1:0]   dw_data;
  logic [DW/8-1:0] dw_strobe;
  logic            dw_resp_valid = 1'b1;
  logic            dw_resp_ready;
  logic [0:0]      dw_resp = 1'b1;

  copperv_lsu #(
    .data_width(DW), .addr_width(AW), .resp_width(bus_resp_width), .timeout_cycles(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
    .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
    .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr), .dw_data(dw_data),
    .dw_strobe(dw_strobe),
    .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready), .dw_resp(dw_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_c;
  int   checks = 0;
  int   failures = 0;

  logic        obs_got;
  int          obs_lat, obs_n_rd, obs_n_wr;
  logic [31:0] obs_rd_addr, obs_wr_addr, obs_wr_data, obs_rdata;
  logic [3:0]  obs_strobe;
  logic        obs_err;

  // Drives one request and records what the bus and response ports do until
  // the response pulse (or a 40-cycle bound). Latency counts from the accept
  // edge: the first sampled negedge after it is cycle 1.
  task automatic run_req(input logic now, input logic wr, input mem_size_e sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
    if (!now) @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    obs_got = 1'b0; obs_lat = 0; obs_n_rd = 0; obs_n_wr = 0;
    obs_rd_addr = '0; obs_wr_addr = '0; obs_wr_data = '0; obs_strobe = '0;
    obs_rdata = '0; obs_err = 1'b0;
    for (int n = 1; n <= 40 && !obs_got; n++) begin
      if (n > 1) @(negedge clk);
      if (dr_addr_valid) begin obs_n_rd++; obs_rd_addr = dr_addr; end
      if (dw_valid) begin
        obs_n_wr++; obs_wr_addr = dw_addr; obs_wr_data = dw_data; obs_strobe = dw_strobe;
      end
      if (resp_valid) begin
        obs_got = 1'b1; obs_lat = n; obs_rdata = resp_rdata; obs_err = resp_err;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, dr_addr_valid, dr_data_ready, dw_valid,
         dw_resp_ready} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b expected=0000000", {req_ready, resp_valid, resp_err,
               dr_addr_valid, dr_data_ready, dw_valid, dw_resp_ready});
    end
    checks++;
    if ({resp_rdata, dr_addr, dw_addr, dw_data, dw_strobe} !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h/%h/%h/%h expected all 0",
               resp_rdata, dr_addr, dw_addr, dw_data, dw_strobe);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b expected=1", req_ready);
    end
  endtask

  task automatic test_load_byte();
    dr_addr_ready = 1'b1; dr_data_valid = 1'b1; dr_data = 32'h80AA_BBCC;
    exp_q.push_back('{32'hFFFF_FF80, 1'b0, 3});
    run_req(1'b0, 1'b0, mem_size_byte, 1'b0, 32'h103, 32'h0);
    exp_c = exp_q.pop_front();
    checks++;
    if (!obs_got || obs_rdata !== exp_c.rdata || obs_err !== exp_c.err || obs_lat != exp_c.lat) begin
      failures++;
      $display("FAIL lb_resp got=%b/%h/%b/%0d expected=1/%h/%b/%0d",
               obs_got, obs_rdata, obs_err, obs_lat, exp_c.rdata, exp_c.err, exp_c.lat);
    end
    checks++;
    if (obs_rd_addr !== 32'h100 || obs_n_rd != 1) begin
      failures++;
      $display("FAIL lb_dr_addr got=%h cycles=%0d expected=00000100 cycles=1", obs_rd_addr, obs_n_rd);
    end
  endtask

  task automatic test_store_hword();
    dw_ready = 1'b1; dw_resp_valid = 1'b1; dw_resp = 1'b1;
    exp_q.push_back('{32'h0, 1'b0, 3});
    run_req(1'b0, 1'b1, mem_size_hword, 1'b0, 32'h202, 32'h1234);
    exp_c = exp_q.pop_front();
    checks++;
    if (!obs_got || obs_rdata !== exp_c.rdata || obs_err !== exp_c.err || obs_lat != exp_c.lat) begin
      failures++;
      $display("FAIL sh_resp got=%b/%h/%b/%0d expected=1/%h/%b/%0d",
               obs_got, obs_rdata, obs_err, obs_lat, exp_c.rdata, exp_c.err, exp_c.lat);
    end
    checks++;
    if (obs_wr_addr !== 32'h200 || obs_wr_data !== 32'h1234_0000 || obs_strobe !== 4'b1100) begin
      failures++;
      $display("FAIL sh_bus got=%h/%h/%b expected=00000200/12340000/1100",
               obs_wr_addr, obs_wr_data, obs_strobe);
    end
  endtask

  task automatic test_misaligned();
    mem_size_e   sz [2] = '{mem_size_word, mem_size_dword};
    logic [31:0] ad [2] = '{32'h101, 32'h0};
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{32'h0, 1'b1, 1});
      run_req(1'b0, 1'b0, sz[i], 1'b0, ad[i], 32'h0);
      exp_c = exp_q.pop_front();
      checks++;
      if (!obs_got || obs_rdata !== exp_c.rdata || obs_err !== exp_c.err ||
          obs_lat != exp_c.lat || obs_n_rd != 0) begin
        failures++;
        $display("FAIL misaligned_%0d got=%b/%h/%b/%0d rd=%0d expected=1/%h/%b/%0d rd=0",
                 i, obs_got, obs_rdata, obs_err, obs_lat, obs_n_rd, exp_c.rdata, exp_c.err, exp_c.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    dw_resp = 1'b0;
    exp_q.push_back('{32'h0, 1'b1, 3});
    run_req(1'b0, 1'b1, mem_size_word, 1'b0, 32'h10, 32'hCAFE_F00D);
    exp_c = exp_q.pop_front();
    checks++;
    if (!obs_got || obs_rdata !== exp_c.rdata || obs_err !== exp_c.err || obs_lat != exp_c.lat) begin
      failures++;
      $display("FAIL sw_bad_resp got=%b/%h/%b/%0d expected=1/%h/%b/%0d",
               obs_got, obs_rdata, obs_err, obs_lat, exp_c.rdata, exp_c.err, exp_c.lat);
    end
    dw_resp = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL pulse_then_ready got=%b%b expected=01", resp_valid, req_ready);
    end
    dr_data = 32'hF00D_0000;
    exp_q.push_back('{32'h0000_F00D, 1'b0, 3});
    run_req(1'b1, 1'b0, mem_size_hword, 1'b1, 32'h2, 32'h0);
    exp_c = exp_q.pop_front();
    checks++;
    if (!obs_got || obs_rdata !== exp_c.rdata || obs_err !== exp_c.err || obs_lat != exp_c.lat) begin
      failures++;
      $display("FAIL lhu_resp got=%b/%h/%b/%0d expected=1/%h/%b/%0d",
               obs_got, obs_rdata, obs_err, obs_lat, exp_c.rdata, exp_c.err, exp_c.lat);
    end
  endtask

  task automatic test_load_patterns();
    mem_size_e   sz [5] = '{mem_size_hword, mem_size_byte, mem_size_byte, mem_size_word, mem_size_hword};
    logic        un [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] ad [5] = '{32'h2, 32'h1, 32'h2, 32'h4, 32'h0};
    logic [31:0] rd [5] = '{32'h8001_0000, 32'h0000_FF00, 32'h007F_0000, 32'hDEAD_BEEF, 32'h1234_ABCD};
    logic [31:0] ex [5] = '{32'hFFFF_8001, 32'h0000_00FF, 32'h0000_007F, 32'hDEAD_BEEF, 32'h0000_ABCD};
    logic [31:0] ea [5] = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h0};
    for (int i = 0; i < 5; i++) begin
      dr_data = rd[i];
      exp_q.push_back('{ex[i], 1'b0, 3});
      run_req(1'b0, 1'b0, sz[i], un[i], ad[i], 32'h0);
      exp_c = exp_q.pop_front();
      checks++;
      if (!obs_got || obs_rdata !== exp_c.rdata || obs_err !== exp_c.err ||
          obs_lat != exp_c.lat || obs_rd_addr !== ea[i]) begin
        failures++;
        $display("FAIL load_pat_%0d got=%b/%h/%b/%0d addr=%h expected=1/%h/%b/%0d addr=%h",
                 i, obs_got, obs_rdata, obs_err, obs_lat, obs_rd_addr,
                 exp_c.rdata, exp_c.err, exp_c.lat, ea[i]);
      end
    end
  endtask

  task automatic test_store_patterns();
    mem_size_e   sz [3] = '{mem_size_byte, mem_size_word, mem_size_hword};
    logic [31:0] ad [3] = '{32'h3, 32'h8, 32'h0};
    logic [31:0] wd [3] = '{32'hAB, 32'hCAFE_F00D, 32'h5678};
    logic [31:0] ed [3] = '{32'hAB00_0000, 32'hCAFE_F00D, 32'h0000_5678};
    logic [3:0]  es [3] = '{4'b1000, 4'b1111, 4'b0011};
    logic [31:0] ea [3] = '{32'h0, 32'h8, 32'h0};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{32'h0, 1'b0, 3});
      run_req(1'b0, 1'b1, sz[i], 1'b0, ad[i], wd[i]);
      exp_c = exp_q.pop_front();
      checks++;
      if (!obs_got || obs_err !== exp_c.err || obs_lat != exp_c.lat || obs_wr_data !== ed[i] ||
          obs_strobe !== es[i] || obs_wr_addr !== ea[i]) begin
        failures++;
        $display("FAIL store_pat_%0d got=%b/%b/%0d %h/%b/%h expected=1/%b/%0d %h/%b/%h",
                 i, obs_got, obs_err, obs_lat, obs_wr_data, obs_strobe, obs_wr_addr,
                 exp_c.err, exp_c.lat, ed[i], es[i], ea[i]);
      end
    end
  endtask

  task automatic test_timeout();
    // Address phase never accepted: 8 cycles of dr_addr_valid, error next.
    dr_addr_ready = 1'b0;
    exp_q.push_back('{32'h0, 1'b1, 9});
    run_req(1'b0, 1'b0, mem_size_word, 1'b0, 32'h40, 32'h0);
    exp_c = exp_q.pop_front();
    checks++;
    if (!obs_got || obs_rdata !== exp_c.rdata || obs_err !== exp_c.err ||
        obs_lat != exp_c.lat || obs_n_rd != 8) begin
      failures++;
      $display("FAIL timeout_addr got=%b/%h/%b/%0d valid_cycles=%0d expected=1/%h/%b/%0d valid_cycles=8",
               obs_got, obs_rdata, obs_err, obs_lat, obs_n_rd, exp_c.rdata, exp_c.err, exp_c.lat);
    end
    checks++;
    if (dr_addr_valid !== 1'b0) begin
      failures++; $display("FAIL timeout_valid_drop got=%b expected=0", dr_addr_valid);
    end
    // Data phase never answered: handshake at cycle 1, then 8 waiting cycles.
    dr_addr_ready = 1'b1; dr_data_valid = 1'b0;
    exp_q.push_back('{32'h0, 1'b1, 10});
    run_req(1'b0, 1'b0, mem_size_word, 1'b0, 32'h44, 32'h0);
    exp_c = exp_q.pop_front();
    checks++;
    if (!obs_got || obs_rdata !== exp_c.rdata || obs_err !== exp_c.err || obs_lat != exp_c.lat) begin
      failures++;
      $display("FAIL timeout_data got=%b/%h/%b/%0d expected=1/%h/%b/%0d",
               obs_got, obs_rdata, obs_err, obs_lat, exp_c.rdata, exp_c.err, exp_c.lat);
    end
    dr_data_valid = 1'b1; dr_data = 32'h1357_9BDF;
    exp_q.push_back('{32'h1357_9BDF, 1'b0, 3});
    run_req(1'b0, 1'b0, mem_size_word, 1'b0, 32'h48, 32'h0);
    exp_c = exp_q.pop_front();
    checks++;
    if (!obs_got || obs_rdata !== exp_c.rdata || obs_err !== exp_c.err || obs_lat != exp_c.lat) begin
      failures++;
      $display("FAIL after_timeout got=%b/%h/%b/%0d expected=1/%h/%b/%0d",
               obs_got, obs_rdata, obs_err, obs_lat, exp_c.rdata, exp_c.err, exp_c.lat);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    dr_addr_ready = 1'b1; dr_data_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = mem_size_word; req_addr = 32'h20;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dr_data_ready !== 1'b1) begin
      failures++; $display("FAIL mid_rd_data_phase got=%b expected=1", dr_data_ready);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid, resp_err, dr_addr_valid, dr_data_ready, dw_valid, dw_resp_ready} !== 7'b0 ||
        {resp_rdata, dr_addr, dw_addr, dw_data, dw_strobe} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b %h/%h expected all 0",
               {req_ready, resp_valid, resp_err, dr_addr_valid, dr_data_ready, dw_valid, dw_resp_ready},
               resp_rdata, dr_addr);
    end
    @(negedge clk);
    rst = 1'b1;
    dr_data_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_after got=pulses %0d ready %b expected=pulses 0 ready 1", pulses, req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_hword();
    test_misaligned();
    test_back_to_back();
    test_load_patterns();
    test_store_patterns();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/copperv_lsu.md
Name: copperv_lsu

Overview:
Parametrised load/store unit between the copperv core datapath and the split data-bus channels: data-read address, data-read data, data-write, and write response.
- Accepts one memory request at a time.
- Generates byte strobes and detects misalignment.
- Extracts and extends load data, checks the write response, and enforces an optional bus timeout.
- Returns a single-cycle response pulse to the core.

Parameters:
data_width, 32, bus data width; 32 or 64; lanes = data_width/8
addr_width, 32, address width
resp_width, 1, write-response width; value 1 (data_write_resp_ok) means success
timeout_cycles, 0, cycles allowed in any bus-wait state before abort; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  LSU idle, can accept a request
req_write  in  1  1=store, 0=load
req_size  in  mem_size_e  byte/hword/word/dword; dword is legal only when data_width=64
req_unsigned  in  1  zero-extend the load (lbu/lhu)
req_addr  in  addr_width  byte address
req_wdata  in  data_width  store data, right-aligned
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  data_width  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, bus error or timeout
dr_addr_valid  out  1  read address valid
dr_addr_ready  in  1  read address ready
dr_addr  out  addr_width  lane-aligned read address
dr_data_valid  in  1  read data valid
dr_data_ready  out  1  read data ready
dr_data  in  data_width  read data
dw_valid  out  1  write request valid
dw_ready  in  1  write request ready
dw_addr  out  addr_width  lane-aligned write address
dw_data  out  data_width  lane-shifted store data
dw_strobe  out  data_width/8  byte enables
dw_resp_valid  in  1  write response valid
dw_resp_ready  out  1  write response ready
dw_resp  in  resp_width  write response code

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_IDLE.
  - All valid/ready outputs are 0; resp_valid=0; resp_err=0.
  - resp_rdata=0, dw_strobe=0, all address and data outputs 0.
  - Timeout counter=0.
  - Reset mid-transaction abandons the transaction silently; no response is produced.
- req_ready=1 only in S_IDLE. Accept = req_valid & req_ready. All request fields are registered on accept.
- Alignment:
  - offset = addr[log2(lanes)-1:0].
  - misaligned = (hword & offset[0]) | (word & offset[1:0]≠0) | (dword & offset≠0).
  - dword with data_width=32 is treated as misaligned.
- States and transitions:
  - S_IDLE → on accept:
    - misaligned → S_DONE with err=1, no bus traffic.
    - load → S_RD_ADDR.
    - store → S_WR.
  - S_RD_ADDR:
    - dr_addr_valid=1; dr_addr = addr with offset bits cleared; held stable until the handshake.
    - On dr_addr_valid & dr_addr_ready → S_RD_DATA.
  - S_RD_DATA:
    - dr_data_ready=1.
    - On dr_data_valid, capture shifted = dr_data >> (offset*8), then sign- or zero-extend from the size width → S_DONE, err=0.
  - S_WR:
    - dw_valid=1; dw_data = wdata << (offset*8); dw_strobe = size_mask << offset.
    - size_mask: byte=1, hword=3, word=F, dword=FF.
    - On dw_valid & dw_ready → S_WR_RESP.
  - S_WR_RESP:
    - dw_resp_ready=1.
    - On dw_resp_valid → S_DONE, err = (dw_resp ≠ data_write_resp_ok).
  - S_DONE:
    - resp_valid=1 for exactly one cycle, with resp_err and resp_rdata (0 for stores and errors) → S_IDLE.
- Timeout:
  - The counter clears on every state change and increments in S_RD_ADDR, S_RD_DATA, S_WR and S_WR_RESP.
  - When timeout_cycles≠0 and counter==timeout_cycles-1 with no handshake that cycle: drop all bus valid/ready outputs, then → S_DONE with err=1.
  - A handshake on the expiry cycle wins over the timeout.
- Latency with an always-ready, zero-wait bus:
  - Load: accept at cycle 0, address handshake at cycle 1, data at cycle 2, resp_valid at cycle 3.
  - Store: same timing.
  - Misaligned: resp_valid at cycle 1.
- Request inputs are ignored outside S_IDLE.
- resp_valid never overlaps req_ready; back-to-back requests may be accepted the cycle after S_DONE.

Decomposition:
- Add to copperv_enums_pkg:
  - mem_size_e {mem_size_byte, mem_size_hword, mem_size_word, mem_size_dword}.
  - lsu_state_e {S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP, S_DONE}.
- Existing data_write_resp_e and bus_resp_width are reused.
- One sub-module, copperv_lsu_align: a combinational function of size, offset and the unsigned flag producing strobe, store shift, load extract/extend and the misaligned flag.

Test Plan:
- Load byte signed, addr=0x103, dr_data=0x80AABBCC → dr_addr=0x100, resp_rdata=0xFFFFFF80, resp_err=0, resp_valid at cycle 3.
- Store hword, addr=0x202, wdata=0x1234, dw_resp=1 → dw_addr=0x200, dw_data=0x12340000, dw_strobe=4'b1100, resp_err=0.
- Load word, addr=0x101 → resp_valid cycle 1, resp_err=1, no dr_addr_valid ever asserted.
- Store word with dw_resp=0 → resp_err=1; then lhu at addr 0x2 with dr_data=0xF00D0000 → resp_rdata=0x0000F00D.
- timeout_cycles=8, dr_addr_ready held 0 → dr_addr_valid high for 8 cycles then drops; resp_err=1 the next cycle; a following request is accepted normally.
- rst pulsed low during S_RD_DATA → all outputs 0 immediately, no resp_valid, req_ready=1 after release.
